bus_responder: RTL and testbench

Memory-mapped target for the generated cores' `addr/size/valid/write/wdata/rdata/ready` bus, i.e. the responder end of the interface the cores initiate on. Decodes one byte-addressed RAM window plus two stdio registers: stdout writes enter a small FIFO drained as a byte stream, and stdin reads pull one byte from an input byte stream. It replaces ad-hoc bench memory so cores can be integrated and simulated against a single synthesizable target.

---
 rtl/bus_responder.sv | 234 +++++++++++++++++++++++
 tb/tb_bus_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_responder.sv
// rtl/bus_responder.sv - bus target: byte-addressed RAM window plus stdio registers
//
// Purpose: responder end of the addr/size/valid/write/wdata/rdata/ready bus.
//   Decodes a RAM window [RAM_BASE, RAM_BASE+RAM_BYTES), a stdout register that
//   pushes bytes into a small FIFO drained as a byte stream, and a stdin register
//   that pulls one byte from an input byte stream per read.
// Optional feature: define BUS_RESPONDER_STDIO_EN to build the stdio registers,
//   stdout FIFO and stream ports. Without it the stdio addresses respond with err
//   and the stream outputs are tied low.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   addr, size, valid, write,
//   wdata                     - request (held with valid until ready)
//   rdata, ready, err         - one-cycle completion pulse with read data / error flag
//   out_data, out_valid,
//   out_ready                 - stdout byte stream (FIFO head)
//   in_data, in_valid,
//   in_ready                  - stdin byte stream
module bus_responder #(
    parameter logic [31:0] RAM_BASE    = 32'h0000_1000,
    parameter int unsigned RAM_BYTES   = 4096,
    parameter logic [31:0] STDOUT_ADDR = 32'h0000_3000,
    parameter logic [31:0] STDIN_ADDR  = 32'h0000_3004,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic        valid,
    input  logic        write,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready
);

    localparam int unsigned RAM_WORDS = RAM_BYTES / 4;
    localparam int unsigned RAW       = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    typedef enum logic {S_IDLE, S_ACK} state_t;
    state_t state;

    logic [31:0]    ram [RAM_WORDS];

    logic           size_bad;
    logic [2:0]     acc_len;
    logic [31:0]    ram_off;
    logic [32:0]    ram_end;
    logic           ram_hit;
    logic           so_hit;
    logic           si_hit;
    logic           req_err;
    logic           idle_req;
    logic           ram_we;
    logic [RAW-1:0] ram_idx;
    logic [3:0]     be;

    // ---------------------------------------------------------------- decode
    always_comb begin
        size_bad = 1'b0;
        acc_len  = 3'd4;
        be       = 4'b1111;
        case (size)
            3'd0: begin
                acc_len = 3'd1;
                be      = 4'b0001 << addr[1:0];
            end
            3'd1: begin
                acc_len  = 3'd2;
                be       = 4'b0011 << addr[1:0];
                size_bad = addr[0];
            end
            3'd2: begin
                size_bad = (addr[1:0] != 2'b00);
            end
            default: begin
                size_bad = 1'b1;
            end
        endcase
    end

    // 33-bit end check so an access touching the last byte of the window still hits
    // while anything spilling past it is treated as unmapped.
    assign ram_off = addr - RAM_BASE;
    assign ram_end = {1'b0, ram_off} + {30'b0, acc_len};
    assign ram_hit = (addr >= RAM_BASE) && (ram_end <= 33'(RAM_BYTES));
    assign ram_idx = ram_off[RAW+1:2];

`ifdef BUS_RESPONDER_STDIO_EN
    assign so_hit = (addr == STDOUT_ADDR);
    assign si_hit = (addr == STDIN_ADDR);
`else
    assign so_hit = 1'b0;
    assign si_hit = 1'b0;
`endif

    assign req_err  = size_bad || !(ram_hit || so_hit || si_hit);
    assign idle_req = (state == S_IDLE) && valid;
    assign ram_we   = idle_req && !req_err && ram_hit && write && !rst;

    // ---------------------------------------------------------------- RAM (not reset)
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    ram[ram_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

`ifdef BUS_RESPONDER_STDIO_EN
    // ---------------------------------------------------------------- stdout FIFO
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_ptr_nxt;
    logic [PW:0]   count;
    logic [PW:0]   count_pop;
    logic [PW:0]   count_nxt;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic [7:0]    head_nxt;

    // Fullness is judged before this cycle's pop, so a push into a full FIFO waits
    // one cycle even when the consumer frees a slot at the same edge.
    assign fifo_full = (count == (PW+1)'(FIFO_DEPTH));
    assign pop       = out_valid && out_ready;
    assign push      = idle_req && !req_err && so_hit && write && !fifo_full;
    assign in_ready  = idle_req && !req_err && si_hit && !write;

    always_comb begin
        rd_ptr_nxt = pop ? rd_ptr + PW'(1) : rd_ptr;
        count_pop  = pop ? count - (PW+1)'(1) : count;
        count_nxt  = push ? count_pop + (PW+1)'(1) : count_pop;
        // A byte pushed into an emptied FIFO becomes the head directly; otherwise
        // the head is the oldest stored entry.
        head_nxt   = (push && (count_pop == '0)) ? wdata[7:0] : fifo_mem[rd_ptr_nxt];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= wdata[7:0];
                wr_ptr           <= wr_ptr + PW'(1);
            end
            rd_ptr    <= rd_ptr_nxt;
            count     <= count_nxt;
            out_valid <= (count_nxt != '0);
            out_data  <= head_nxt;
        end
    end
`else
    assign out_valid = 1'b0;
    assign out_data  = 8'h00;
    assign in_ready  = 1'b0;

    logic unused_stdio;
    assign unused_stdio = &{1'b0, out_ready, in_data, in_valid};
`endif

    // ---------------------------------------------------------------- bus FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            ready <= 1'b0;
            err   <= 1'b0;
            rdata <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    ready <= 1'b0;
                    if (valid) begin
                        if (req_err) begin
                            state <= S_ACK;
                            ready <= 1'b1;
                            err   <= 1'b1;
                            rdata <= 32'h0;
                        end else if (ram_hit) begin
                            // Reads return the whole aligned word whatever the size.
                            state <= S_ACK;
                            ready <= 1'b1;
                            err   <= 1'b0;
                            rdata <= ram[ram_idx];
`ifdef BUS_RESPONDER_STDIO_EN
                        end else if (so_hit) begin
                            if (!write || !fifo_full) begin
                                state <= S_ACK;
                                ready <= 1'b1;
                                err   <= 1'b0;
                                rdata <= 32'h0;
                            end
                        end else if (si_hit) begin
                            if (write) begin
                                state <= S_ACK;
                                ready <= 1'b1;
                                err   <= 1'b0;
                                rdata <= 32'h0;
                            end else if (in_valid) begin
                                state <= S_ACK;
                                ready <= 1'b1;
                                err   <= 1'b0;
                                rdata <= {24'h0, in_data};
                            end
`endif
                        end
                    end
                end
                S_ACK: begin
                    // The request still visible here is the one just completed.
                    state <= S_IDLE;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_responder.sv
// tb/tb_bus_responder.sv - self-checking bench for bus_responder
module tb_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [2:0]  size;
    logic        valid;
    logic        write;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;

    bus_responder dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .size      (size),
        .valid     (valid),
        .write     (write),
        .wdata     (wdata),
        .rdata     (rdata),
        .ready     (ready),
        .err       (err),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [2:0]  s;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic        chk_rd;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] got[$];

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) got.push_back(out_data);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic w, input logic [31:0] a, input logic [2:0] s,
                       input logic [31:0] d, input logic [31:0] exp_rd,
                       input logic exp_err, input logic chk_rd);
        vec_t v;
        v.w = w; v.a = a; v.s = s; v.d = d;
        v.exp_rd = exp_rd; v.exp_err = exp_err; v.chk_rd = chk_rd;
        vecs.push_back(v);
    endtask

    task automatic set_req(input logic w, input logic [31:0] a, input logic [2:0] s,
                           input logic [31:0] d);
        valid = 1'b1; write = w; addr = a; size = s; wdata = d;
    endtask

    task automatic wait_ready(input string name, input int budget, output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ready && lat < budget);
        if (!ready) check({name, " timeout ready"}, 32'(ready), 32'h1);
    endtask

    task automatic do_req(input string name, input logic w, input logic [31:0] a,
                          input logic [2:0] s, input logic [31:0] d,
                          input logic [31:0] exp_rd, input logic exp_err, input logic chk_rd);
        int lat;
        set_req(w, a, s, d);
        wait_ready(name, 20, lat);
        check({name, " latency"}, 32'(lat), 32'd1);
        check({name, " err"}, 32'(err), 32'(exp_err));
        if (chk_rd) check({name, " rdata"}, rdata, exp_rd);
        valid = 1'b0;
        @(posedge clk); #1;
        check({name, " pulse"}, 32'(ready), 32'h0);
    endtask

    initial begin
        int lat;
        int seen;

        rst = 1'b1; valid = 1'b0; write = 1'b0; addr = '0; size = '0; wdata = '0;
        out_ready = 1'b0; in_data = 8'h00; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", 32'(ready), 32'h0);
        check("reset err", 32'(err), 32'h0);
        check("reset rdata", rdata, 32'h0);
        check("reset out_valid", 32'(out_valid), 32'h0);
        check("reset in_ready", 32'(in_ready), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        add(1'b1, 32'h1100, 3'd2, 32'h11223344, 32'h0,        1'b0, 1'b0);
        add(1'b0, 32'h1100, 3'd2, 32'h0,        32'h11223344, 1'b0, 1'b1);
        add(1'b1, 32'h1101, 3'd0, 32'h0000AB00, 32'h0,        1'b0, 1'b0);
        add(1'b0, 32'h1100, 3'd2, 32'h0,        32'h1122AB44, 1'b0, 1'b1);
        add(1'b1, 32'h1102, 3'd1, 32'hBEEF0000, 32'h0,        1'b0, 1'b0);
        add(1'b0, 32'h1100, 3'd2, 32'h0,        32'hBEEFAB44, 1'b0, 1'b1);
        add(1'b0, 32'h1103, 3'd0, 32'h0,        32'hBEEFAB44, 1'b0, 1'b1);
        add(1'b0, 32'h1102, 3'd2, 32'h0,        32'h0,        1'b1, 1'b1);
        add(1'b0, 32'h1100, 3'd3, 32'h0,        32'h0,        1'b1, 1'b1);
        add(1'b0, 32'h0000, 3'd2, 32'h0,        32'h0,        1'b1, 1'b1);
        add(1'b1, 32'h1101, 3'd1, 32'h99999999, 32'h0,        1'b1, 1'b1);
        add(1'b1, 32'h1100, 3'd7, 32'h77777777, 32'h0,        1'b1, 1'b1);
        add(1'b0, 32'h1100, 3'd2, 32'h0,        32'hBEEFAB44, 1'b0, 1'b1);
        add(1'b1, 32'h1FFC, 3'd2, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0);
        add(1'b0, 32'h1FFE, 3'd1, 32'h0,        32'hCAFEF00D, 1'b0, 1'b1);
        add(1'b0, 32'h2000, 3'd0, 32'h0,        32'h0,        1'b1, 1'b1);
        add(1'b1, 32'h0FFC, 3'd2, 32'h12345678, 32'h0,        1'b1, 1'b1);
`ifdef BUS_RESPONDER_STDIO_EN
        add(1'b0, 32'h3000, 3'd2, 32'h0,        32'h0,        1'b0, 1'b1);
        add(1'b1, 32'h3004, 3'd2, 32'h99,       32'h0,        1'b0, 1'b0);
`else
        add(1'b1, 32'h3000, 3'd0, 32'h41,       32'h0,        1'b1, 1'b1);
        add(1'b0, 32'h3004, 3'd2, 32'h0,        32'h0,        1'b1, 1'b1);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            do_req($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].s, vecs[i].d,
                   vecs[i].exp_rd, vecs[i].exp_err, vecs[i].chk_rd);
        end

`ifdef BUS_RESPONDER_STDIO_EN
        // stdout: fill FIFO, stall the fifth write, then drain
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_req($sformatf("stdout%0d", i), 1'b1, 32'h3000, 3'd0, 32'h41 + i, 32'h0, 1'b0, 1'b0);
        end
        check("fifo out_valid", 32'(out_valid), 32'h1);
        check("fifo head", 32'(out_data), 32'h41);
        set_req(1'b1, 32'h3000, 3'd0, 32'h45);
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (ready) seen++;
        end
        check("stdout stall", 32'(seen), 32'h0);
        out_ready = 1'b1;
        wait_ready("stdout4", 20, lat);
        check("stdout4 latency", 32'(lat), 32'd2);
        check("stdout4 err", 32'(err), 32'h0);
        valid = 1'b0;
        @(posedge clk); #1;
        do_req("stdout5", 1'b1, 32'h3000, 3'd0, 32'h46, 32'h0, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("stream length", 32'(got.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("stream byte%0d", i),
                  32'((i < got.size()) ? got[i] : 8'hxx), 32'h41 + i);
        end
        check("drained out_valid", 32'(out_valid), 32'h0);

        // stdin: stall without a byte, then deliver one
        in_valid = 1'b0;
        set_req(1'b0, 32'h3004, 3'd2, 32'h0);
        #1;
        check("stdin in_ready", 32'(in_ready), 32'h1);
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (ready) seen++;
        end
        check("stdin stall", 32'(seen), 32'h0);
        in_data = 8'h5A; in_valid = 1'b1;
        wait_ready("stdin", 20, lat);
        check("stdin latency", 32'(lat), 32'd1);
        check("stdin rdata", rdata, 32'h0000005A);
        check("stdin err", 32'(err), 32'h0);
        check("stdin in_ready ack", 32'(in_ready), 32'h0);
        in_valid = 1'b0; valid = 1'b0;
        @(posedge clk); #1;

        // reset with bytes queued and a stalled request pending
        out_ready = 1'b0;
        do_req("queue0", 1'b1, 32'h3000, 3'd0, 32'h61, 32'h0, 1'b0, 1'b0);
        do_req("queue1", 1'b1, 32'h3000, 3'd0, 32'h62, 32'h0, 1'b0, 1'b0);
        check("queued out_valid", 32'(out_valid), 32'h1);
        set_req(1'b0, 32'h3004, 3'd2, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst flush out_valid", 32'(out_valid), 32'h0);
        check("rst ready", 32'(ready), 32'h0);
        rst = 1'b0; valid = 1'b0;
        @(posedge clk); #1;
`else
        in_valid = 1'b1;
        set_req(1'b0, 32'h3004, 3'd2, 32'h0);
        #1;
        check("stdin disabled in_ready", 32'(in_ready), 32'h0);
        valid = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        check("stdout disabled out_valid", 32'(out_valid), 32'h0);
`endif

        // RAM write presented in the reset cycle must not land
        set_req(1'b1, 32'h1100, 3'd2, 32'hDEADBEEF);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst write ready", 32'(ready), 32'h0);
        rst = 1'b0; valid = 1'b0;
        @(posedge clk); #1;
        do_req("ram retained", 1'b0, 32'h1100, 3'd2, 32'h0, 32'hBEEFAB44, 1'b0, 1'b1);
        do_req("ram top retained", 1'b0, 32'h1FFC, 3'd2, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
